// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns debounced press/release pulses into
// single-click, double-click and long-press event pulses.
module button_gesture_decoder #(
    parameter int LONG_PRESS_CYCLES = 3000000,
    parameter int DOUBLE_GAP_CYCLES = 900000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_pressed,
    input  logic btn_released,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int MAX_CYC = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                             LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS1   = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_single;
    logic             r_double;
    logic             r_long;
    logic             r_busy;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment so a stuck counter can never wrap.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (btn_pressed) begin
                        r_state <= PRESS1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                PRESS1: begin
                    if (btn_released) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_long  <= 1'b1;
                        r_state <= WAIT_REL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                GAP: begin
                    if (btn_pressed) begin
                        r_double <= 1'b1;
                        r_state  <= WAIT_REL;
                        r_cnt    <= '0;
                    end else if (r_cnt == GAP_LAST) begin
                        r_single <= 1'b1;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt    <= w_cnt_inc;
                    end
                end
                WAIT_REL: begin
                    if (btn_released) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign busy         = r_busy;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with short timing
// parameters (long press 20 cycles, double-click gap 8 cycles).
module tb_button_gesture_decoder;

    logic clk;
    logic rst_n;
    logic btn_pressed;
    logic btn_released;
    logic single_click;
    logic double_click;
    logic long_press;
    logic busy;

    int n_pass;
    int n_total;

    button_gesture_decoder #(
        .LONG_PRESS_CYCLES(20),
        .DOUBLE_GAP_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pressed (btn_pressed),
        .btn_released(btn_released),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Cycle c drives inputs sampled at edge c; values seen after that
    // edge belong to cycle c+1. Events are {single, double, long}.
    task automatic run_gesture(input string tag,
                               input int p0, input int r0,
                               input int p1, input int r1,
                               input logic [2:0] ev, input int ev_cyc,
                               input int n);
        logic [2:0] exp;
        for (int c = 0; c < n; c++) begin
            btn_pressed  = (c == p0) || (c == p1);
            btn_released = (c == r0) || (c == r1);
            @(posedge clk);
            #1;
            exp = (c + 1 == ev_cyc) ? ev : 3'b000;
            chk($sformatf("%s_ev_c%0d", tag, c + 1),
                {29'd0, single_click, double_click, long_press},
                {29'd0, exp});
            if (c == p0)
                chk($sformatf("%s_busy_on", tag), {31'd0, busy}, 32'd1);
        end
        btn_pressed  = 1'b0;
        btn_released = 1'b0;
        chk($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {28'd0, single_click, double_click, long_press, busy},
            32'd0);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        btn_pressed  = 1'b0;
        btn_released = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            btn_pressed  = i[0];
            btn_released = ~i[0];
            @(posedge clk);
            #1;
            chk_all_zero($sformatf("rst_hold_%0d", i));
        end
        btn_pressed  = 1'b0;
        btn_released = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all_zero($sformatf("rst_rel_%0d", i));
        end

        run_gesture("single", 0, 5, -1, -1, 3'b100, 14, 20);
        run_gesture("double", 0, 5, 10, 40, 3'b010, 11, 45);
        run_gesture("long", 0, 50, -1, -1, 3'b001, 21, 70);
        run_gesture("rel_at_19", 0, 20, -1, -1, 3'b100, 29, 35);
        run_gesture("press_at_7", 0, 5, 13, 16, 3'b010, 14, 20);
        run_gesture("both_press1", 0, 3, 3, -1, 3'b100, 12, 18);

        // Async reset in the middle of the gap
        btn_pressed = 1'b1;
        @(posedge clk);
        #1;
        btn_pressed = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        btn_released = 1'b1;
        @(posedge clk);
        #1;
        btn_released = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("gap_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("gap_rst_now");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            chk_all_zero($sformatf("gap_post_rst_%0d", i));
        end

        run_gesture("after_rst", 0, 5, -1, -1, 3'b100, 14, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
